// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A clock divider produces a one-clk pixel tick; x/y raster counters advance on
// that tick and every sync/blank/position output is decoded from the registered
// counters, so they move only on tick edges. Line/frame strobes mark the final
// tick of a line/frame, and a wrapping frame counter tracks completed frames.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 29,
    parameter int CLK_DIV   = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 10,
    parameter int FC_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             pixel_en,
    output logic             HS,
    output logic             VS,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             blank,
    output logic             last_column,
    output logic             last_row,
    output logic             line_end,
    output logic             frame_end,
    output logic [FC_W-1:0]  frame_count
);

    // Raster geometry, folded into counter-width constants once.
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] Y_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] X_VIS_LAST = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] Y_VIS_LAST = CNT_W'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic             pixel_tick;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             x_at_last;
    logic             y_at_last;
    logic             hs_active;
    logic             vs_active;

    // Pixel-clock divider. With CLK_DIV == 1 every enabled clock is a pixel,
    // so no divider state exists at all.
    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

            logic [DIV_W-1:0] div_q, div_d;

            // Next divider count: advance while enabled, wrap at CLK_DIV-1.
            always_comb begin
                div_d = div_q;
                if (enable) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end

            // Divider register; reset returns it to phase 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end

            assign pixel_tick = enable && (div_q == DIV_LAST);
        end else begin : g_nodiv
            assign pixel_tick = enable;
        end
    endgenerate

    assign x_at_last = (x_q == X_LAST);
    assign y_at_last = (y_q == Y_LAST);

    // Next raster position and frame count; everything holds without a tick.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (pixel_tick) begin
            if (x_at_last) begin
                x_d = '0;
                if (y_at_last) begin
                    y_d  = '0;
                    fc_d = fc_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Raster and frame-count registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            fc_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
        end
    end

    // Sync windows decoded straight from the registered counters.
    always_comb begin
        hs_active = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
        vs_active = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    end

    assign HS          = hs_active ? HS_POL : ~HS_POL;
    assign VS          = vs_active ? VS_POL : ~VS_POL;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign blank       = (x_q >= X_VIS) || (y_q >= Y_VIS);
    assign last_column = (x_q == X_VIS_LAST);
    assign last_row    = (y_q == Y_VIS_LAST);
    assign pixel_en    = pixel_tick;
    assign line_end    = pixel_tick && x_at_last;
    assign frame_end   = pixel_tick && x_at_last && y_at_last;
    assign frame_count = fc_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 timing block in the iosystem VGA core. Every horizontal and vertical interval, sync polarity and pixel-clock divide ratio is set by a parameter. Beyond sync and coordinates, it adds a run enable, line and frame strobes, and a frame counter. It sits between the system clock and the VGA character/pixel pipeline, which consumes `pixel_en`, the coordinates and `blank`.

## Interface
- `H_VISIBLE`, 640: visible columns
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: visible rows
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 29: vertical back porch, in lines
- `CLK_DIV`, 2: clk cycles per pixel, must be ≥1
- `HS_POL`, 0: active level of `HS` (0 = active-low)
- `VS_POL`, 0: active level of `VS`
- `CNT_W`, 10: coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W
- `FC_W`, 16: frame counter width

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `enable` in 1: run; when low, all state freezes
- `pixel_en` out 1: pixel tick, one clk wide
- `HS` out 1: horizontal sync
- `VS` out 1: vertical sync
- `pixel_x` out CNT_W: current column
- `pixel_y` out CNT_W: current row
- `blank` out 1: outside the visible area
- `last_column` out 1: `pixel_x == H_VISIBLE-1`
- `last_row` out 1: `pixel_y == V_VISIBLE-1`
- `line_end` out 1: strobe on the final tick of each line
- `frame_end` out 1: strobe on the final tick of each frame
- `frame_count` out FC_W: count of completed frames

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP (default 800).
  - V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP (default 521).
- Divider `div` counts 0..CLK_DIV-1.
  - It advances only while `enable` is high and wraps at CLK_DIV-1.
  - `pixel_en = enable && (div == CLK_DIV-1)`, combinational.
  - With CLK_DIV=1, `pixel_en = enable`.
- x/y counters update only on clk edges where `pixel_en` is high.
  - x wraps from H_TOTAL-1 to 0.
  - y increments only when x wraps, and wraps from V_TOTAL-1 to 0.
- `HS` equals HS_POL when H_VISIBLE+H_FP ≤ x ≤ H_VISIBLE+H_FP+H_SYNC-1; otherwise it equals ~HS_POL.
- `VS` is the same function of y, using the V_* parameters and VS_POL.
- `blank = (x ≥ H_VISIBLE) || (y ≥ V_VISIBLE)`. The condition is OR: blanking is asserted in either porch/sync region.
- `line_end = pixel_en && x == H_TOTAL-1`.
- `frame_end = line_end && y == V_TOTAL-1`.
- `frame_count` increments on `frame_end` and wraps modulo 2^FC_W with no saturation.
- All outputs except the strobes and `pixel_en` are combinational decodes of registered x/y, so they are glitch-free relative to the pixel tick.
- `enable` low: `div`, x, y and `frame_count` all hold, `pixel_en` and the strobes are 0, and HS/VS/blank hold their decoded values.
- `rst` has priority over `enable`.

## Timing
- Reset state: `div`=0, x=0, y=0, `frame_count`=0.
- Output values after reset:
  - `pixel_x`=0, `pixel_y`=0, `blank`=0.
  - `HS`=~HS_POL and `VS`=~VS_POL (both 1 at default polarity).
  - `last_column`=0, `last_row`=0, `line_end`=0, `frame_end`=0.
  - `pixel_en`=0 for CLK_DIV>1.
- First tick: the first `pixel_en` arrives CLK_DIV-1 enabled clocks after reset release; x becomes 1 on the following edge.
- Period: each coordinate holds for exactly CLK_DIV enabled clocks. One frame is H_TOTAL·V_TOTAL·CLK_DIV enabled clocks (833,600 at default).
- Latency: HS/VS/blank change on the same edge that updates x/y, so there is zero latency relative to the coordinates.
- Reset mid-frame: on the next edge, return to the reset state regardless of `div` or `enable`. No partial strobe is emitted.
- Wrap coincidence: on the frame-wrap tick, `line_end` and `frame_end` are high in the same cycle, and `frame_count` updates on that edge.

## Test plan
- Reset defaults: assert `rst` for 3 clocks with `enable`=1, then release.
  - Before release: x=y=0, `HS`=`VS`=1, `blank`=0, `frame_count`=0.
  - First `pixel_en` appears on clock 1 after release; x=1 on clock 2.
- Default full frame:
  - `HS` low for exactly x=656..751, which is 96 ticks (192 clocks) per line.
  - `VS` low for exactly y=490..491.
  - `blank` high for x ≥ 640 or y ≥ 480.
  - `frame_end` pulses once per 833,600 clocks, and `frame_count` then reads 1.
- Tiny config: H=4/1/1/1, V=3/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1.
  - x sequence is 0..6 repeating; `HS`=1 only at x=5; `blank`=1 at x=4..6.
  - `line_end` fires every 7 clocks; `frame_end` fires every 42 clocks; `VS`=1 only at y=4.
- Enable freeze: drop `enable` for 10 clocks at x=100, y=20 (default config).
  - x, y, `div` and `frame_count` hold; `pixel_en`=0 throughout.
  - Counting resumes with x=101 exactly CLK_DIV enabled clocks after re-enable.
- Reset mid-operation: assert `rst` for one clock at x=700, y=495.
  - Next state is the reset state; no `line_end`/`frame_end` is seen.
- Counter wrap: FC_W=2 with the tiny config.
  - After 4 frames `frame_count` returns to 0.
  - Simultaneous `line_end`/`frame_end` is checked on every wrap.
